// File: rtl/mult_ctrl.sv
// Sequencer for the n-bit shift-add multiplier datapath: operand capture, load/add/shift strobes, product hand-off.
// Latency: n+2 cycles from acceptance with SPLIT=0, 2n+popcount(mplier)+2 with SPLIT=1.
// Backpressure: DONE holds the product with no strobes until out_ready; in_ready is high only in IDLE.
module mult_ctrl #(
  parameter int n     = 8,
  parameter int SPLIT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [n-1:0]   in_mcand,
  input  logic [n-1:0]   in_mplier,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*n-1:0] out_product,
  output logic           busy,
  output logic           load,
  output logic           add,
  output logic           shift,
  output logic [n-1:0]   sbn,
  output logic [n-1:0]   sn,
  input  logic           cnt_eq_0,
  input  logic           b0,
  input  logic [2*n-1:0] tich
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_TEST,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [n-1:0]   sn_q, sn_d;
  logic [n-1:0]   sbn_q, sbn_d;

  // State and operand registers; reset clears both so sn/sbn read zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sn_q    <= '0;
      sbn_q   <= '0;
    end else begin
      state_q <= state_d;
      sn_q    <= sn_d;
      sbn_q   <= sbn_d;
    end
  end

  // Next-state, operand capture and Moore strobes (add in CALC follows b0).
  always_comb begin
    state_d   = state_q;
    sn_d      = sn_q;
    sbn_d     = sbn_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    load      = 1'b0;
    add       = 1'b0;
    shift     = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          sbn_d   = in_mcand;
          sn_d    = in_mplier;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = (SPLIT != 0) ? S_TEST : S_CALC;
      end
      S_CALC: begin
        if (cnt_eq_0) begin
          state_d = S_DONE;
        end else begin
          shift = 1'b1;
          add   = b0;
        end
      end
      S_TEST: begin
        if (cnt_eq_0)  state_d = S_DONE;
        else if (b0)   state_d = S_ADD;
        else           state_d = S_SHIFT;
      end
      S_ADD: begin
        add     = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shift   = 1'b1;
        state_d = S_TEST;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel wins over everything, including a coincident output handshake.
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  assign sn          = sn_q;
  assign sbn         = sbn_q;
  assign out_product = tich;

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Sequencing controller for the `n`-bit shift-add multiplier datapath: it accepts operand pairs over a valid/ready input handshake, drives the datapath's `load`/`add`/`shift` strobes from its `cnt_eq_0`/`b0` status, and presents the `2n`-bit product over a valid/ready output handshake with backpressure. One multiplication is in flight at a time. The block sits between the request source and the datapath instance. The datapath's operand inputs `sn`/`sbn` are driven from this block's operand registers, and its product output `tich` is routed back through this block.

## Interface
Parameters:
- `n`, 8: operand width; product width is `2n`.
- `SPLIT`, 0: 0 = add and shift issued in the same cycle (1 cycle per bit); 1 = classic ASM with separate TEST/ADD/SHIFT states.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low; also drives the datapath's `rst_n`.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block accepts operands; high only in IDLE.
- `in_mcand` in n: multiplicand.
- `in_mplier` in n: multiplier.
- `abort` in 1: synchronous cancel of the current operation.
- `out_valid` out 1: product valid; high only in DONE.
- `out_ready` in 1: consumer accepts product.
- `out_product` out 2n: product, equal to datapath `tich`.
- `busy` out 1: high in any state except IDLE.
- `load`, `add`, `shift` out 1 each: datapath strobes.
- `sbn` out n: multiplicand register, to datapath `sbn`.
- `sn` out n: multiplier register, to datapath `sn`.
- `cnt_eq_0`, `b0` in 1 each: datapath status.
- `tich` in 2n: datapath product.

## Operation
- States: IDLE, LOAD, CALC (SPLIT=0), TEST/ADD/SHIFT (SPLIT=1), DONE. The strobes are Moore outputs of the state, except `add` in CALC, which equals `b0`.
- IDLE:
  - `in_ready`=1.
  - When `in_valid`=1 at a clock edge: capture `in_mcand` into `sbn` and `in_mplier` into `sn`, then go to LOAD.
- LOAD: `load`=1 for exactly one cycle, then go to CALC or TEST.
- CALC (SPLIT=0):
  - If `cnt_eq_0`: no strobes; go to DONE.
  - Otherwise: `shift`=1, `add`=`b0`; stay in CALC.
- TEST (SPLIT=1): no strobes.
  - `cnt_eq_0` → DONE.
  - Otherwise `b0` → ADD, else → SHIFT.
- ADD: `add`=1, then → SHIFT.
- SHIFT: `shift`=1, then → TEST.
- DONE:
  - `out_valid`=1; `out_product`=`tich`, held stable because no strobes are asserted.
  - `out_valid`&&`out_ready` → IDLE.
- `abort`=1 in any non-IDLE state → IDLE next cycle. No `out_valid` is produced. `abort` is ignored in IDLE.
- `load`, `add` and `shift` are never asserted outside the states listed above. `load` is never asserted together with `add` or `shift`.
- Product width is `2n`, so wrap is impossible for unsigned operands: (2^n−1)² < 2^2n.
- The `sn`/`sbn` registers change only on input handshake.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State IDLE.
  - `in_ready`=1; `out_valid`=0, `busy`=0, `load`=0, `add`=0, `shift`=0; `sn`=0, `sbn`=0.
  - Reset mid-operation discards the operation, with no `out_valid`.
- Call the acceptance edge T0. LOAD occupies the cycle after T0; the datapath is loaded at edge T1.
- Latency with SPLIT=0:
  - Shifts occur at edges T2..T(n+1).
  - CALC sees `cnt_eq_0` in the cycle after T(n+1).
  - `out_valid` rises after edge T(n+2), i.e. `n+2` cycles after acceptance, independent of operand values.
- Latency with SPLIT=1: `out_valid` rises `2n + popcount(in_mplier) + 2` cycles after acceptance.
- Throughput: the next input handshake is possible at the earliest one cycle after the output handshake edge (DONE→IDLE, then IDLE accepts).
- Backpressure: DONE persists indefinitely while `out_ready`=0. `out_product` and `out_valid` stay constant and `in_ready` stays 0.
- Simultaneous `abort` and `out_ready` in DONE: → IDLE. This is treated as abort, and no handshake is counted.

## Test plan
- n=8, SPLIT=0, mcand=13, mplier=11 → `out_valid` exactly 10 cycles after acceptance, product 143. `add` is high on 3 of the 8 shift cycles.
- n=8, SPLIT=1, mcand=13, mplier=11 → product 143, `out_valid` exactly 21 cycles after acceptance. Check the state trace TEST→ADD→SHIFT for set bits and TEST→SHIFT for clear bits.
- mcand=255, mplier=255 → 65025. Hold `out_ready`=0 for 5 cycles → product stable, `in_ready`=0 throughout, then one handshake → `in_ready`=1 next cycle.
- mcand=0, mplier=200 and mcand=200, mplier=0 → product 0. `add` is never asserted when mplier=0.
- Abort in the 4th CALC cycle → IDLE the next cycle, no `out_valid`. A following request 7×9 yields 63 with nominal latency.
- `rst_n` low for one edge mid-CALC → all outputs at their reset values the next cycle. A subsequent 100×3 yields 300.
